exec_scheduler: RTL and testbench

EXEC_SCHEDULER -- requirements
Module: exec_scheduler

---
 rtl/tomasulo_pkg.sv | 28 ++
 rtl/rr_pick.sv | 37 +++
 rtl/exec_scheduler.sv | 159 +++++++++++++++
 tb/tb_exec_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo execution scheduler: default sizing,
// functional-unit opcodes and the multiply/divide unit state encoding.
package tomasulo_pkg;

  localparam int N_RS_DEF    = 3;
  localparam int TAG_W_DEF   = 3;
  localparam int MUL_LAT_DEF = 3;
  localparam int DIV_LAT_DEF = 6;

  typedef enum logic [3:0] {
    FN_ADD = 4'b0000,
    FN_SUB = 4'b0001,
    FN_MUL = 4'b0010,
    FN_DIV = 4'b0011
  } func_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // Bits needed to index n items; never less than one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first ready index at or after i_ptr,
// wrapping at N. o_sel is 0 whenever nothing is ready.
module rr_pick
  import tomasulo_pkg::*;
#(
  parameter int N     = N_RS_DEF,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     i_rdy,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any,
  output logic [IDX_W-1:0] o_sel
);

  localparam logic [IDX_W:0] NW = (IDX_W+1)'(N);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_any = 1'b0;
    o_sel = '0;
    w_sum = '0;
    w_idx = '0;
    // ptr < N and k < N, so one conditional subtract performs the wrap.
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_sum >= NW) w_sum = w_sum - NW;
      w_idx = w_sum[IDX_W-1:0];
      if (!o_any && i_rdy[w_idx]) begin
        o_any = 1'b1;
        o_sel = w_idx;
      end
    end
  end

endmodule

// File: rtl/exec_scheduler.sv
// Issue scheduler for one add/sub unit and one non-pipelined mul/div unit,
// arbitrating a single common data bus with mul/div taking priority.
module exec_scheduler
  import tomasulo_pkg::*;
#(
  parameter int N_RS    = N_RS_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_RS-1:0]       add_rdy,
  input  logic [N_RS*TAG_W-1:0] add_rob,
  input  logic [N_RS-1:0]       mul_rdy,
  input  logic [N_RS-1:0]       mul_isdiv,
  input  logic [N_RS*TAG_W-1:0] mul_rob,
  input  logic                  flush,
  output logic                  add_issue,
  output logic [1:0]            add_sel,
  output logic                  mul_issue,
  output logic [1:0]            mul_sel,
  output logic                  mul_busy,
  output logic                  cdb_valid,
  output logic                  cdb_src,
  output logic [TAG_W-1:0]      cdb_rob
);

  localparam int IDX_W   = idx_w(N_RS);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = idx_w(MAX_LAT);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [IDX_W:0]   NW      = (IDX_W+1)'(N_RS);

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] sel);
    logic [IDX_W:0] s;
    s = {1'b0, sel} + (IDX_W+1)'(1);
    if (s >= NW) s = '0;
    return s[IDX_W-1:0];
  endfunction

  mul_state_e       r_state;
  mul_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [TAG_W-1:0] r_mul_tag;
  logic             r_add_pend;
  logic [TAG_W-1:0] r_add_tag;
  logic [IDX_W-1:0] r_add_ptr;
  logic [IDX_W-1:0] r_mul_ptr;

  logic             w_add_any;
  logic [IDX_W-1:0] w_add_sel;
  logic             w_mul_any;
  logic [IDX_W-1:0] w_mul_sel;
  logic             w_mul_done;
  logic             w_add_grant;
  logic [TAG_W-1:0] w_add_tags [N_RS];
  logic [TAG_W-1:0] w_mul_tags [N_RS];

  for (genvar g = 0; g < N_RS; g++) begin : g_unpack
    assign w_add_tags[g] = add_rob[g*TAG_W +: TAG_W];
    assign w_mul_tags[g] = mul_rob[g*TAG_W +: TAG_W];
  end

  rr_pick #(.N(N_RS), .IDX_W(IDX_W)) u_add_pick (
    .i_rdy (add_rdy),
    .i_ptr (r_add_ptr),
    .o_any (w_add_any),
    .o_sel (w_add_sel)
  );

  rr_pick #(.N(N_RS), .IDX_W(IDX_W)) u_mul_pick (
    .i_rdy (mul_rdy),
    .i_ptr (r_mul_ptr),
    .o_any (w_mul_any),
    .o_sel (w_mul_sel)
  );

  // The finished mul/div result always wins the bus; a pending add waits.
  assign w_mul_done  = (r_state == ST_DONE);
  assign w_add_grant = r_add_pend & ~w_mul_done;

  // rst_n gating keeps issue low while reset is held with stations ready.
  assign add_issue = rst_n & ~flush & w_add_any & (~r_add_pend | w_add_grant);
  assign mul_issue = rst_n & ~flush & w_mul_any & (r_state == ST_IDLE);
  assign add_sel   = 2'(w_add_sel);
  assign mul_sel   = 2'(w_mul_sel);
  assign mul_busy  = (r_state != ST_IDLE);

  assign cdb_valid = r_add_pend | w_mul_done;
  assign cdb_src   = w_mul_done;
  assign cdb_rob   = w_mul_done ? r_mul_tag : (r_add_pend ? r_add_tag : '0);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      ST_IDLE: begin
        if (mul_issue) begin
          w_count_nxt = mul_isdiv[w_mul_sel] ? DIV_CNT : MUL_CNT;
          w_state_nxt = (w_count_nxt == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_count <= CNT_ONE) begin
          w_count_nxt = '0;
          w_state_nxt = ST_DONE;
        end else begin
          w_count_nxt = r_count - CNT_ONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_tag  <= '0;
      r_add_pend <= 1'b0;
      r_add_tag  <= '0;
      r_add_ptr  <= '0;
      r_mul_ptr  <= '0;
    end else begin
      if (mul_issue) begin
        r_mul_tag <= w_mul_tags[w_mul_sel];
        r_mul_ptr <= ptr_after(w_mul_sel);
      end
      if (flush) begin
        r_add_pend <= 1'b0;
      end else if (add_issue) begin
        r_add_pend <= 1'b1;
        r_add_tag  <= w_add_tags[w_add_sel];
      end else if (w_add_grant) begin
        r_add_pend <= 1'b0;
      end
      if (add_issue) r_add_ptr <= ptr_after(w_add_sel);
    end
  end

endmodule

// File: tb/tb_exec_scheduler.sv
// Bench for exec_scheduler: directed scenarios plus a randomized run against
// a cycle-count based reference model of the scheduler.
module tb_exec_scheduler;

  localparam int NRS = 3;
  localparam int TW  = 3;
  localparam int ML  = 3;
  localparam int DL  = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush;
  logic [2:0] add_rdy, mul_rdy, mul_isdiv;
  logic [8:0] add_rob, mul_rob;
  logic       add_issue, mul_issue, mul_busy, cdb_valid, cdb_src;
  logic [1:0] add_sel, mul_sel;
  logic [2:0] cdb_rob;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_scheduler #(.N_RS(NRS), .TAG_W(TW), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .rst_n(rst_n),
    .add_rdy(add_rdy), .add_rob(add_rob),
    .mul_rdy(mul_rdy), .mul_isdiv(mul_isdiv), .mul_rob(mul_rob),
    .flush(flush),
    .add_issue(add_issue), .add_sel(add_sel),
    .mul_issue(mul_issue), .mul_sel(mul_sel),
    .mul_busy(mul_busy),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob(cdb_rob)
  );

  function automatic logic [8:0] put_tag(input int idx, input int tag);
    logic [8:0] v;
    v = '0;
    v[idx*3 +: 3] = 3'(tag);
    return v;
  endfunction

  function automatic logic [2:0] get_tag(input logic [8:0] v, input int idx);
    return v[idx*3 +: 3];
  endfunction

  // First ready index scanning from ptr with wrap, or -1 if none.
  function automatic int pick(input logic [2:0] rdy, input int ptr);
    for (int k = 0; k < NRS; k++) begin
      int i;
      i = (ptr + k) % NRS;
      if (rdy[i]) return i;
    end
    return -1;
  endfunction

  task automatic idle_in();
    add_rdy = '0; mul_rdy = '0; mul_isdiv = '0;
    add_rob = '0; mul_rob = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_in();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_in();
    rst_n = 1'b0;
    add_rdy = 3'b111; mul_rdy = 3'b111;
    #2;
    checks++;
    if ({add_issue, mul_issue, mul_busy, cdb_valid, cdb_src, cdb_rob} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000000",
               {add_issue, mul_issue, mul_busy, cdb_valid, cdb_src, cdb_rob});
    end
    @(negedge clk);
    idle_in();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({mul_busy, cdb_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_release got %b want 00", {mul_busy, cdb_valid});
    end
  endtask

  task automatic test_add_rr();
    logic [2:0] exp_rob;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      add_rdy = 3'b111;
      add_rob = {3'd3, 3'd2, 3'd1};
      #1;
      checks++;
      if (add_issue !== 1'b1 || add_sel !== 2'(c % 3)) begin
        errors++;
        $display("FAIL add_rr_sel c=%0d got issue=%b sel=%0d want 1/%0d", c, add_issue, add_sel, c % 3);
      end
      exp_rob = (c >= 1) ? 3'((c - 1) % 3 + 1) : 3'd0;
      checks++;
      if ({cdb_valid, cdb_src, cdb_rob} !== {(c >= 1), 1'b0, exp_rob}) begin
        errors++;
        $display("FAIL add_rr_cdb c=%0d got v=%b s=%b rob=%0d want v=%b s=0 rob=%0d",
                 c, cdb_valid, cdb_src, cdb_rob, (c >= 1), exp_rob);
      end
    end
    @(negedge clk);
    add_rdy = '0;
    #1;
    checks++;
    if ({cdb_valid, cdb_src, cdb_rob} !== {1'b1, 1'b0, 3'd1}) begin
      errors++; $display("FAIL add_rr_tail got v=%b rob=%0d want v=1 rob=1", cdb_valid, cdb_rob);
    end
    @(negedge clk);
    #1;
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++; $display("FAIL add_rr_drained got %b want 0", cdb_valid);
    end
  endtask

  task automatic test_mul();
    do_reset();
    @(negedge clk);
    mul_rdy = 3'b010; mul_isdiv = 3'b000; mul_rob = put_tag(1, 5);
    #1;
    checks++;
    if ({mul_issue, mul_sel, mul_busy} !== {1'b1, 2'd1, 1'b0}) begin
      errors++; $display("FAIL mul_issue got %b%0d%b want 110", mul_issue, mul_sel, mul_busy);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      mul_rdy = '0;
      #1;
      checks++;
      if (mul_busy !== (c <= 3)) begin
        errors++; $display("FAIL mul_busy c=%0d got %b want %b", c, mul_busy, (c <= 3));
      end
      checks++;
      if (c == 3) begin
        if ({cdb_valid, cdb_src, cdb_rob} !== {1'b1, 1'b1, 3'd5}) begin
          errors++; $display("FAIL mul_cdb got v=%b s=%b rob=%0d want 1/1/5", cdb_valid, cdb_src, cdb_rob);
        end
      end else if (cdb_valid !== 1'b0) begin
        errors++; $display("FAIL mul_cdb_idle c=%0d got %b want 0", c, cdb_valid);
      end
    end
  endtask

  task automatic test_div_block();
    do_reset();
    @(negedge clk);
    mul_rdy = 3'b001; mul_isdiv = 3'b001; mul_rob = put_tag(0, 2);
    #1;
    checks++;
    if ({mul_issue, mul_sel} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL div_issue got %b/%0d want 1/0", mul_issue, mul_sel);
    end
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      mul_rdy = 3'b100; mul_isdiv = 3'b000; mul_rob = put_tag(2, 7);
      #1;
      checks++;
      if (mul_issue !== (c == 7)) begin
        errors++; $display("FAIL div_block c=%0d got issue=%b want %b", c, mul_issue, (c == 7));
      end
      checks++;
      if (c == 6) begin
        if ({cdb_valid, cdb_src, cdb_rob} !== {1'b1, 1'b1, 3'd2}) begin
          errors++; $display("FAIL div_cdb got v=%b s=%b rob=%0d want 1/1/2", cdb_valid, cdb_src, cdb_rob);
        end
      end else if (c == 7) begin
        if (mul_sel !== 2'd2 || mul_busy !== 1'b0) begin
          errors++; $display("FAIL div_after got sel=%0d busy=%b want 2/0", mul_sel, mul_busy);
        end
      end else if (cdb_valid !== 1'b0 || mul_busy !== 1'b1) begin
        errors++; $display("FAIL div_run c=%0d got v=%b busy=%b want 0/1", c, cdb_valid, mul_busy);
      end
    end
  endtask

  task automatic test_conflict();
    do_reset();
    @(negedge clk);
    mul_rdy = 3'b001; mul_rob = put_tag(0, 4);
    #1;
    checks++;
    if (mul_issue !== 1'b1) begin
      errors++; $display("FAIL conf_mul_issue got %b want 1", mul_issue);
    end
    @(negedge clk);
    idle_in();
    @(negedge clk);
    add_rdy = 3'b001; add_rob = put_tag(0, 1);
    #1;
    checks++;
    if (add_issue !== 1'b1) begin
      errors++; $display("FAIL conf_add_issue got %b want 1", add_issue);
    end
    @(negedge clk);
    add_rdy = 3'b010; add_rob = put_tag(1, 6);
    #1;
    checks++;
    if ({cdb_valid, cdb_src, cdb_rob, add_issue} !== {1'b1, 1'b1, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL conf_cycle got v=%b s=%b rob=%0d ai=%b want 1/1/4/0", cdb_valid, cdb_src, cdb_rob, add_issue);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({cdb_valid, cdb_src, cdb_rob, add_issue, add_sel} !== {1'b1, 1'b0, 3'd1, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL conf_next got v=%b s=%b rob=%0d ai=%b sel=%0d want 1/0/1/1/1",
               cdb_valid, cdb_src, cdb_rob, add_issue, add_sel);
    end
    @(negedge clk);
    add_rdy = '0;
    #1;
    checks++;
    if ({cdb_valid, cdb_src, cdb_rob} !== {1'b1, 1'b0, 3'd6}) begin
      errors++; $display("FAIL conf_refill got v=%b rob=%0d want 1/6", cdb_valid, cdb_rob);
    end
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk);
    mul_rdy = 3'b001; mul_isdiv = 3'b001; mul_rob = put_tag(0, 3);
    @(negedge clk);
    idle_in();
    add_rdy = 3'b001; add_rob = put_tag(0, 5);
    #1;
    checks++;
    if (add_issue !== 1'b1 || mul_busy !== 1'b1) begin
      errors++; $display("FAIL flush_setup got ai=%b busy=%b want 1/1", add_issue, mul_busy);
    end
    @(negedge clk);
    flush = 1'b1; add_rdy = 3'b010; mul_rdy = 3'b010;
    #1;
    checks++;
    if ({add_issue, mul_issue} !== 2'b00) begin
      errors++; $display("FAIL flush_issue got %b want 00", {add_issue, mul_issue});
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      idle_in();
      #1;
      checks++;
      if ({mul_busy, cdb_valid} !== 2'b00) begin
        errors++; $display("FAIL flush_after c=%0d got busy=%b v=%b rob=%0d want 0/0", c, mul_busy, cdb_valid, cdb_rob);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    mul_rdy = 3'b001; mul_rob = put_tag(0, 6);
    #1;
    checks++;
    if (mul_issue !== 1'b1) begin
      errors++; $display("FAIL rmid_issue got %b want 1", mul_issue);
    end
    @(negedge clk);
    idle_in();
    @(negedge clk);
    mul_rdy = 3'b100; add_rdy = 3'b111;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({add_issue, mul_issue, mul_busy, cdb_valid, cdb_src, cdb_rob} !== 8'b0) begin
      errors++;
      $display("FAIL rmid_outputs got %b want 00000000",
               {add_issue, mul_issue, mul_busy, cdb_valid, cdb_src, cdb_rob});
    end
    @(negedge clk);
    rst_n = 1'b1; add_rdy = '0; mul_rdy = 3'b100; mul_rob = put_tag(2, 1);
    #1;
    checks++;
    if ({mul_issue, mul_sel, cdb_valid} !== {1'b1, 2'd2, 1'b0}) begin
      errors++; $display("FAIL rmid_release got mi=%b sel=%0d v=%b want 1/2/0", mul_issue, mul_sel, cdb_valid);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      idle_in();
      #1;
      checks++;
      if (c < 3 && cdb_valid !== 1'b0) begin
        errors++; $display("FAIL rmid_stale c=%0d got v=%b rob=%0d want 0", c, cdb_valid, cdb_rob);
      end else if (c == 3 && {cdb_valid, cdb_src, cdb_rob} !== {1'b1, 1'b1, 3'd1}) begin
        errors++; $display("FAIL rmid_new got v=%b s=%b rob=%0d want 1/1/1", cdb_valid, cdb_src, cdb_rob);
      end
    end
  endtask

  task automatic test_random();
    int         m_aptr, m_mptr, m_done_at, cyc, ap, mp;
    bit         m_apend, m_minf, mdone, grant, e_ai, e_mi;
    logic [2:0] m_atag, m_mtag, e_rob;
    logic [11:0] got, exp_v;
    do_reset();
    m_aptr = 0; m_mptr = 0; m_apend = 0; m_minf = 0;
    m_atag = '0; m_mtag = '0; m_done_at = 0; cyc = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      add_rdy   = 3'($urandom);
      mul_rdy   = 3'($urandom) & 3'($urandom);
      mul_isdiv = 3'($urandom);
      add_rob   = 9'($urandom);
      mul_rob   = 9'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      #1;
      mdone = m_minf && (cyc >= m_done_at);
      ap    = pick(add_rdy, m_aptr);
      mp    = pick(mul_rdy, m_mptr);
      grant = m_apend && !mdone;
      e_ai  = !flush && (ap >= 0) && (!m_apend || grant);
      e_mi  = !flush && (mp >= 0) && !m_minf;
      e_rob = mdone ? m_mtag : (m_apend ? m_atag : 3'd0);
      exp_v = {e_ai, 2'((ap >= 0) ? ap : 0), e_mi, 2'((mp >= 0) ? mp : 0),
               m_minf, (m_apend || mdone), mdone, e_rob};
      got   = {add_issue, add_sel, mul_issue, mul_sel, mul_busy, cdb_valid, cdb_src, cdb_rob};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL random cyc=%0d got %b want %b (ai sel mi sel busy v src rob)", cyc, got, exp_v);
      end
      if (flush) begin
        m_apend = 0;
        m_minf  = 0;
      end else begin
        if (e_ai) begin
          m_apend = 1;
          m_atag  = get_tag(add_rob, ap);
        end else if (grant) begin
          m_apend = 0;
        end
        if (mdone) m_minf = 0;
        if (e_mi) begin
          m_minf    = 1;
          m_done_at = cyc + (mul_isdiv[mp] ? DL : ML);
          m_mtag    = get_tag(mul_rob, mp);
        end
      end
      if (e_ai) m_aptr = (ap + 1) % NRS;
      if (e_mi) m_mptr = (mp + 1) % NRS;
      cyc++;
    end
    @(negedge clk);
    idle_in();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_add_rr();
    test_mul();
    test_div_block();
    test_conflict();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
